matrix_store_ctrl: RTL and testbench

Sequencer that stores one incoming matrix into the shared element BRAM under control of the matrix directory manager. It validates dimensions, requests a slot and base address, and streams elements into BRAM at consecutive addresses. It then commits the slot metadata and reports done or an error code. It sits between the input front end (UART/switch entry) and the directory manager plus BRAM write port.

---
 rtl/matrix_store_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_matrix_store_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_store_ctrl.sv
// matrix_store_ctrl: stores one matrix into the shared element BRAM.
// Flow: validate dims -> ask the directory manager for a slot -> stream
// elements to consecutive addresses -> commit slot metadata -> done.
// Any failure ends with a one-cycle error pulse and a sticky error_code.

module matrix_store_ctrl #(
   parameter int MAX_DIM       = 5,
   parameter int ELEMENT_WIDTH = 8,
   parameter int ADDR_WIDTH    = 12
) (
   input  logic                     clk,
   input  logic                     rst,
   // front-end command
   input  logic                     start,
   input  logic [4:0]               m,
   input  logic [4:0]               n,
   input  logic                     abort,
   output logic                     busy,
   // element stream
   input  logic                     in_valid,
   input  logic [ELEMENT_WIDTH-1:0] in_data,
   output logic                     in_ready,
   // directory manager: allocation
   output logic                     alloc_req,
   output logic [4:0]               alloc_m,
   output logic [4:0]               alloc_n,
   input  logic [3:0]               alloc_slot,
   input  logic [ADDR_WIDTH-1:0]    alloc_addr,
   input  logic                     alloc_valid,
   // BRAM write port
   output logic                     bram_we,
   output logic [ADDR_WIDTH-1:0]    bram_addr,
   output logic [ELEMENT_WIDTH-1:0] bram_din,
   // directory manager: commit
   output logic                     commit_req,
   output logic [3:0]               commit_slot,
   output logic [4:0]               commit_m,
   output logic [4:0]               commit_n,
   output logic [ADDR_WIDTH-1:0]    commit_addr,
   // status
   output logic                     done,
   output logic [3:0]               done_slot,
   output logic                     error,
   output logic [1:0]               error_code
);

   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_ALLOC      = 3'd1;
   localparam logic [2:0] S_ALLOC_WAIT = 3'd2;
   localparam logic [2:0] S_WRITE      = 3'd3;
   localparam logic [2:0] S_COMMIT     = 3'd4;
   localparam logic [2:0] S_FINISH     = 3'd5;

   localparam logic [1:0] ERR_NONE  = 2'd0;
   localparam logic [1:0] ERR_DIM   = 2'd1;
   localparam logic [1:0] ERR_SPACE = 2'd2;
   localparam logic [1:0] ERR_ABORT = 2'd3;

   logic [2:0]            state;
   logic [2:0]            state_nxt;
   logic [9:0]            elem_cnt;
   logic [9:0]            elem_total;
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic                  dims_ok;
   logic                  accept;
   logic                  last_elem;
   logic                  grant;

   assign dims_ok   = (m != 5'd0) && (m <= 5'(MAX_DIM)) &&
                      (n != 5'd0) && (n <= 5'(MAX_DIM));
   assign in_ready  = (state == S_WRITE);
   // abort wins over a same-cycle element: the offered element is dropped
   assign accept    = in_ready && in_valid && !abort;
   assign last_elem = (elem_cnt == elem_total - 10'd1);
   // manager granted a slot and nobody cancelled in the same cycle
   assign grant     = (state == S_ALLOC_WAIT) && alloc_valid && !abort;

   // metadata commit uses the same dims that were sent with the request
   assign commit_m  = alloc_m;
   assign commit_n  = alloc_n;

   // Next-state selection; abort outranks every other event in ALLOC..WRITE
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:       if (start && dims_ok) state_nxt = S_ALLOC;
         S_ALLOC:      state_nxt = abort ? S_IDLE : S_ALLOC_WAIT;
         S_ALLOC_WAIT: state_nxt = (abort || !alloc_valid) ? S_IDLE : S_WRITE;
         S_WRITE: begin
            if (abort)                      state_nxt = S_IDLE;
            else if (accept && last_elem)   state_nxt = S_COMMIT;
         end
         S_COMMIT:     state_nxt = S_FINISH;
         S_FINISH:     state_nxt = S_IDLE;
         default:      state_nxt = S_IDLE;
      endcase
   end

   // State register; busy/alloc_req decoded from next state so they are registered
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         busy      <= 1'b0;
         alloc_req <= 1'b0;
      end else begin
         state     <= state_nxt;
         busy      <= (state_nxt != S_IDLE);
         alloc_req <= (state_nxt == S_ALLOC);
      end
   end

   // Latch request dims on start, then slot/base/size once the manager grants
   always_ff @(posedge clk) begin
      if (rst) begin
         alloc_m     <= 5'd0;
         alloc_n     <= 5'd0;
         commit_slot <= 4'd0;
         commit_addr <= '0;
         elem_total  <= 10'd0;
      end else begin
         if (state == S_IDLE && start) begin
            alloc_m <= m;
            alloc_n <= n;
         end
         if (grant) begin
            commit_slot <= alloc_slot;
            commit_addr <= alloc_addr;
            elem_total  <= 10'(alloc_m) * 10'(alloc_n);
         end
      end
   end

   // Element write port: one registered BRAM write per accepted element
   always_ff @(posedge clk) begin
      if (rst) begin
         bram_we   <= 1'b0;
         bram_addr <= '0;
         bram_din  <= '0;
         wr_ptr    <= '0;
         elem_cnt  <= 10'd0;
      end else begin
         bram_we <= accept;
         if (grant) begin
            wr_ptr   <= alloc_addr;
            elem_cnt <= 10'd0;
         end else if (accept) begin
            // pointer wraps naturally at the top of the address space
            bram_addr <= wr_ptr;
            bram_din  <= in_data;
            wr_ptr    <= wr_ptr + ADDR_WIDTH'(1);
            elem_cnt  <= elem_cnt + 10'd1;
         end
      end
   end

   // Commit pulse lines up with the BRAM write of the last element
   always_ff @(posedge clk) begin
      if (rst) commit_req <= 1'b0;
      else     commit_req <= (state == S_WRITE) && (state_nxt == S_COMMIT);
   end

   // Completion/error reporting; error_code is sticky until the next accepted start
   always_ff @(posedge clk) begin
      if (rst) begin
         done       <= 1'b0;
         done_slot  <= 4'hF;
         error      <= 1'b0;
         error_code <= ERR_NONE;
      end else begin
         done  <= (state == S_COMMIT);
         error <= 1'b0;
         if (state == S_COMMIT) done_slot <= commit_slot;
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (!dims_ok) begin
                     error      <= 1'b1;
                     error_code <= ERR_DIM;
                  end else begin
                     error_code <= ERR_NONE;
                  end
               end
            end
            S_ALLOC, S_WRITE: begin
               if (abort) begin
                  error      <= 1'b1;
                  error_code <= ERR_ABORT;
               end
            end
            S_ALLOC_WAIT: begin
               if (abort) begin
                  error      <= 1'b1;
                  error_code <= ERR_ABORT;
               end else if (!alloc_valid) begin
                  error      <= 1'b1;
                  error_code <= ERR_SPACE;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_matrix_store_ctrl.sv
// Bench for matrix_store_ctrl: a table of directed store scenarios, a
// mid-write reset sequence and randomized stores. Expected behaviour comes
// from a transaction-level model (outcome code, element list, metadata).

module tb_matrix_store_ctrl;
   localparam int EW = 8;
   localparam int AW = 12;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0, abort = 1'b0, in_valid = 1'b0, alloc_valid = 1'b0;
   logic [4:0]    m = 5'd0, n = 5'd0;
   logic [EW-1:0] in_data = '0;
   logic [3:0]    alloc_slot = 4'd0;
   logic [AW-1:0] alloc_addr = '0;
   logic          busy, in_ready, alloc_req, bram_we, commit_req, done, error;
   logic [4:0]    alloc_m, alloc_n, commit_m, commit_n;
   logic [AW-1:0] bram_addr, commit_addr;
   logic [EW-1:0] bram_din;
   logic [3:0]    commit_slot, done_slot;
   logic [1:0]    error_code;

   matrix_store_ctrl #(.MAX_DIM(5), .ELEMENT_WIDTH(EW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .m(m), .n(n), .abort(abort), .busy(busy),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .alloc_req(alloc_req), .alloc_m(alloc_m), .alloc_n(alloc_n),
      .alloc_slot(alloc_slot), .alloc_addr(alloc_addr), .alloc_valid(alloc_valid),
      .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
      .commit_req(commit_req), .commit_slot(commit_slot), .commit_m(commit_m),
      .commit_n(commit_n), .commit_addr(commit_addr),
      .done(done), .done_slot(done_slot), .error(error), .error_code(error_code)
   );

   always #5 clk = ~clk;

   // scenario record: stimulus knobs followed by expected outcome
   // abort_at: -1 none, -3 in ALLOC, -2 in ALLOC_WAIT, k>=0 with element k offered
   typedef struct {
      int m, n, av, slot, base, gap, abort_at, abort_start, abort_late, stray, tail;
      int exp_code, exp_w, exp_done;
   } vec_t;

   typedef struct { int c; logic [AW-1:0] a; logic [EW-1:0] d; } wr_t;
   typedef struct { int c; logic [3:0] s; logic [4:0] m, n; logic [AW-1:0] a; } cm_t;

   // event log, written only by the monitor
   wr_t        wq[$];
   cm_t        cq[$];
   int         done_c[$];
   int         err_c[$];
   logic [1:0] err_q[$];
   int         busy_rise[$];
   int         n_alloc = 0, n_busy = 0, cyc = 0;
   logic       busy_d = 1'b0;

   int         n_cmp = 0, n_bad = 0;
   logic [3:0] last_done = 4'hF;

   // monitor samples 1ns after each rising edge
   always begin
      @(posedge clk); #1;
      cyc = cyc + 1;
      if (bram_we)    wq.push_back('{cyc, bram_addr, bram_din});
      if (commit_req) cq.push_back('{cyc, commit_slot, commit_m, commit_n, commit_addr});
      if (done)       done_c.push_back(cyc);
      if (error) begin err_c.push_back(cyc); err_q.push_back(error_code); end
      if (alloc_req)  n_alloc = n_alloc + 1;
      if (busy)       n_busy = n_busy + 1;
      if (busy && !busy_d) busy_rise.push_back(cyc);
      busy_d = busy;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // reference outcome of a store, from the behavioural rules only
   function automatic vec_t model(input vec_t v);
      vec_t r = v;
      int total = v.m * v.n;
      r.exp_w = 0; r.exp_done = 0;
      if (v.m < 1 || v.m > 5 || v.n < 1 || v.n > 5)  r.exp_code = 1;
      else if (v.abort_at == -3 || v.abort_at == -2)  r.exp_code = 3;
      else if (v.av == 0)                             r.exp_code = 2;
      else if (v.abort_at >= 0 && v.abort_at < total) begin
         r.exp_code = 3; r.exp_w = v.abort_at;
      end else begin
         r.exp_code = 0; r.exp_w = total; r.exp_done = 1;
      end
      return r;
   endfunction

   // drive one store starting at a negedge, then check the logged events
   task automatic run(input vec_t v, input string tag);
      int w0, c0, d0, e0, a0, b0, r0, total, k, ph, budget;
      bit ok, aborted, vld;
      logic [EW-1:0] acc[$];
      w0 = wq.size(); c0 = cq.size(); d0 = done_c.size(); e0 = err_c.size();
      a0 = n_alloc; b0 = n_busy; r0 = busy_rise.size();
      ok = (v.m >= 1 && v.m <= 5 && v.n >= 1 && v.n <= 5);
      total = v.m * v.n;
      aborted = 0;
      start = 1'b1; m = 5'(v.m); n = 5'(v.n); abort = (v.abort_start != 0);
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      if (ok) begin
         if (v.abort_at == -3) abort = 1'b1;
         @(negedge clk);
         abort = 1'b0;
         if (v.abort_at != -3) begin
            alloc_valid = (v.av != 0); alloc_slot = 4'(v.slot); alloc_addr = AW'(v.base);
            if (v.abort_at == -2) abort = 1'b1;
            @(negedge clk);
            alloc_valid = 1'b0; abort = 1'b0;
            if (v.av != 0 && v.abort_at > -2) begin
               k = 0; ph = 0; budget = 400;
               while (k < total && !aborted) begin
                  if (budget == 0) begin
                     chk({tag, " element budget expired"}, 32'(k), 32'(total));
                     break;
                  end
                  budget--;
                  case (v.gap)
                     0:       vld = 1'b1;
                     1:       vld = (ph % 2 == 0);
                     default: vld = ($urandom % 3 != 0);
                  endcase
                  ph++;
                  if (v.abort_at == k) begin abort = 1'b1; vld = 1'b1; end
                  in_valid = vld; in_data = EW'($urandom);
                  if (v.stray != 0) begin
                     start = ($urandom % 4 == 0); m = 5'($urandom); n = 5'($urandom);
                  end
                  @(negedge clk);
                  if (abort) aborted = 1'b1;
                  else if (vld) begin acc.push_back(in_data); k++; end
               end
               in_valid = 1'b0; abort = 1'b0; start = 1'b0;
               if (!aborted && v.abort_late != 0) begin
                  abort = 1'b1; @(negedge clk); abort = 1'b0;
               end
            end
         end
      end
      repeat (v.tail) @(negedge clk);
      if (v.exp_done != 0) last_done = 4'(v.slot);

      chk({tag, " error_code"}, 32'(error_code), 32'(v.exp_code));
      chk({tag, " error pulses"}, 32'(err_c.size() - e0), 32'(v.exp_code != 0));
      if (err_c.size() > e0)
         chk({tag, " code at pulse"}, 32'(err_q[e0]), 32'(v.exp_code));
      chk({tag, " alloc_req cycles"}, 32'(n_alloc - a0), 32'(ok));
      if (!ok) chk({tag, " busy cycles"}, 32'(n_busy - b0), 0);
      chk({tag, " write count"}, 32'(wq.size() - w0), 32'(v.exp_w));
      for (int i = 0; i < v.exp_w && w0 + i < wq.size() && i < acc.size(); i++) begin
         chk($sformatf("%s wr%0d addr", tag, i), 32'(wq[w0+i].a), 32'((v.base + i) & 12'hFFF));
         chk($sformatf("%s wr%0d data", tag, i), 32'(wq[w0+i].d), 32'(acc[i]));
      end
      chk({tag, " commit count"}, 32'(cq.size() - c0), 32'(v.exp_done));
      chk({tag, " done count"}, 32'(done_c.size() - d0), 32'(v.exp_done));
      if (v.exp_done != 0 && cq.size() > c0 && done_c.size() > d0 && wq.size() > w0) begin
         chk({tag, " commit meta"}, {cq[c0].s, cq[c0].m, cq[c0].n, cq[c0].a},
             {4'(v.slot), 5'(v.m), 5'(v.n), 12'(v.base)});
         chk({tag, " commit with last write"}, 32'(cq[c0].c), 32'(wq[wq.size()-1].c));
         chk({tag, " done after commit"}, 32'(done_c[d0]), 32'(cq[c0].c + 1));
         // start cycle is the one before busy rises; done lands total+4 after it
         if (v.gap == 0 && busy_rise.size() > r0)
            chk({tag, " latency"}, 32'(done_c[d0] - busy_rise[r0]), 32'(total + 3));
      end
      chk({tag, " done_slot"}, 32'(done_slot), 32'(last_done));
      chk({tag, " idle busy"}, 32'(busy), 0);
   endtask

   vec_t tbl[13];
   int   w0, c0, e0, d0;

   initial begin
      //          m  n av slot base   gap abt  as al st tail code w  done
      tbl[0]  = '{2, 3, 1, 4, 'h010,  0, -1,  0, 0, 0, 3,   0,  6, 1};
      tbl[1]  = '{0, 3, 1, 1, 'h000,  0, -1,  0, 0, 0, 3,   1,  0, 0};
      tbl[2]  = '{6, 2, 1, 1, 'h000,  0, -1,  0, 0, 0, 3,   1,  0, 0};
      tbl[3]  = '{3, 3, 0, 2, 'h200,  0, -1,  0, 0, 0, 3,   2,  0, 0};
      tbl[4]  = '{2, 2, 1, 7, 'h020,  1, -1,  0, 0, 0, 3,   0,  4, 1};
      tbl[5]  = '{3, 3, 1, 2, 'h040,  0,  4,  0, 0, 0, 0,   3,  4, 0};
      tbl[6]  = '{1, 1, 1, 9, 'h0AB,  0, -1,  1, 0, 0, 3,   0,  1, 1};
      tbl[7]  = '{5, 5, 1, 0, 'hFF0,  2, -1,  0, 1, 0, 3,   0, 25, 1};
      tbl[8]  = '{4, 5, 1, 3, 'h100,  0, -3,  0, 0, 0, 3,   3,  0, 0};
      tbl[9]  = '{4, 4, 1, 3, 'h100,  0, -2,  0, 0, 0, 3,   3,  0, 0};
      tbl[10] = '{5, 1, 1, 3, 'h7FF,  0, -1,  0, 0, 1, 3,   0,  5, 1};
      tbl[11] = '{5, 6, 1, 3, 'h000,  0, -1,  0, 0, 0, 3,   1,  0, 0};
      tbl[12] = '{3, 2, 1, 8, 'h300,  0,  0,  0, 0, 0, 3,   3,  0, 0};

      // reset state
      repeat (3) @(negedge clk);
      chk("rst busy", 32'(busy), 0);
      chk("rst pulses", {alloc_req, bram_we, commit_req, done, error}, 0);
      chk("rst error_code", 32'(error_code), 0);
      chk("rst done_slot", 32'(done_slot), 32'hF);
      chk("rst latched", {alloc_m, alloc_n, commit_slot, commit_addr}, 0);
      chk("rst in_ready", 32'(in_ready), 0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 13; i++) run(tbl[i], $sformatf("vec%0d", i));

      // reset in the middle of a 2x2 store, with an element offered on the reset edge
      w0 = wq.size(); c0 = cq.size(); e0 = err_c.size(); d0 = done_c.size();
      start = 1'b1; m = 5'd2; n = 5'd2;
      @(negedge clk); start = 1'b0;
      @(negedge clk); alloc_valid = 1'b1; alloc_slot = 4'd5; alloc_addr = 12'h100;
      @(negedge clk); alloc_valid = 1'b0; in_valid = 1'b1; in_data = 8'hAA;
      @(negedge clk); in_data = 8'hBB;
      @(negedge clk); in_data = 8'hCC; rst = 1'b1;
      @(negedge clk); rst = 1'b0; in_valid = 1'b0;
      last_done = 4'hF;
      chk("midrst busy", 32'(busy), 0);
      chk("midrst we/commit/err", {bram_we, commit_req, error, done}, 0);
      chk("midrst latched", {alloc_m, commit_addr, error_code}, 0);
      chk("midrst done_slot", 32'(done_slot), 32'hF);
      chk("midrst in_ready", 32'(in_ready), 0);
      repeat (3) @(negedge clk);
      chk("midrst writes", 32'(wq.size() - w0), 2);
      chk("midrst no commit/err/done",
          32'((cq.size() - c0) + (err_c.size() - e0) + (done_c.size() - d0)), 0);

      // address wrap across the top of BRAM
      begin
         vec_t v;
         v = '{2, 2, 1, 6, 'hFFE, 0, -1, 0, 0, 0, 3, 0, 4, 1};
         run(v, "wrap");
      end

      // randomized stores against the model
      for (int i = 0; i < 40; i++) begin
         vec_t v;
         v.m = $urandom_range(0, 6); v.n = $urandom_range(0, 6);
         v.av = ($urandom % 8 != 0); v.slot = $urandom_range(0, 15);
         v.base = $urandom_range(0, 4095); v.gap = $urandom_range(0, 2);
         v.abort_at = ($urandom % 4 == 0) ? int'($urandom_range(0, 30)) - 3 : -1;
         v.abort_start = $urandom % 2; v.abort_late = $urandom % 2;
         v.stray = $urandom % 2; v.tail = 3;
         v = model(v);
         run(v, $sformatf("rnd%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

endmodule
